// File: rtl/adder_pkg.sv
// adder_pkg: definitions shared by the chunked ripple adder and its chunk slice.
//   state_e       - sequencer states (IDLE accepting, BUSY one chunk per cycle,
//                   DONE result held until the consumer takes it)
//   nchunk()      - number of chunk steps for a given operand width
//   chunk_cfg_ok()- legal WIDTH/CHUNK pairing, evaluated at elaboration
package adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // A partial top chunk is not supported: every step must be a full
  // CHUNK-bit slice, so WIDTH has to divide evenly.
  function automatic bit chunk_cfg_ok(input int width, input int chunk);
    return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/chunk_ripple_adder.sv
// chunk_ripple_adder: purely combinational CHUNK-bit ripple-carry adder.
//   a, b          - CHUNK-bit addends
//   carry_in      - carry into bit 0
//   sum           - CHUNK-bit sum
//   carry_out     - carry out of the top bit
//   msb_carry_in  - carry into the top bit, used by the parent for signed
//                   overflow when this is the most-significant chunk
module chunk_ripple_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             carry_in,
  output logic [CHUNK-1:0] sum,
  output logic             carry_out,
  output logic             msb_carry_in
);

  logic [CHUNK:0] c;

  // Full-adder chain, bit 0 upward. Kept in one process so the carry vector
  // is evaluated as a single ordered ripple.
  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = carry_in;
    for (int i = 0; i < CHUNK; i++) begin
      sum[i]  = a[i] ^ b[i] ^ c[i];
      c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign carry_out    = c[CHUNK];
  assign msb_carry_in = c[CHUNK-1];

endmodule

// File: rtl/chunked_ripple_adder.sv
// chunked_ripple_adder: multi-cycle add/subtract, CHUNK bits per clock,
// least-significant chunk first, carry held in a register between cycles.
//   clk, rst              - clock, asynchronous active-high reset
//   in_valid / in_ready   - operation handshake (a, b, carry_in, sub)
//   a, b                  - WIDTH-bit operands
//   carry_in              - carry into bit 0 (add mode only)
//   sub                   - 0: a+b+carry_in, 1: a-b (a+~b+1)
//   out_valid / out_ready - result handshake
//   sum                   - WIDTH-bit result
//   carry_out             - carry out of MSB (sub: 1 = no borrow)
//   overflow              - two's-complement overflow
// Latency is NCHUNK edges from accept to out_valid; a result retiring on
// the same edge as a new accept gives one op per NCHUNK+1 cycles.
module chunked_ripple_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  if (!chunk_cfg_ok(WIDTH, CHUNK)) begin : g_cfg_err
    $error("chunked_ripple_adder: need 1 <= CHUNK <= WIDTH and WIDTH %% CHUNK == 0");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;     // already inverted for subtract
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             accept;
  logic [31:0]      base;
  logic [CHUNK-1:0] ch_a, ch_b, ch_s;
  logic             ch_co, ch_msb_ci;

  // Single chunk adder shared across all steps; the counter selects the slice.
  assign base = 32'(cnt_q) * 32'(CHUNK);
  assign ch_a = a_q[base +: CHUNK];
  assign ch_b = b_q[base +: CHUNK];

  chunk_ripple_adder #(.CHUNK(CHUNK)) u_chunk (
    .a            (ch_a),
    .b            (ch_b),
    .carry_in     (carry_q),
    .sum          (ch_s),
    .carry_out    (ch_co),
    .msb_carry_in (ch_msb_ci)
  );

  assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign out_valid = (state_q == S_DONE);
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          // Subtract is a + ~b + 1; carry_in is ignored in that mode.
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : carry_in;
          cnt_d   = '0;
          sum_d   = '0;
          state_d = S_BUSY;
        end else if (state_q == S_DONE && out_ready) begin
          // Retire without a follow-on op: result values stay on the pins.
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        sum_d[base +: CHUNK] = ch_s;
        carry_d              = ch_co;
        if (cnt_q == LAST) begin
          // Top chunk: its top bit is bit WIDTH-1 of the word.
          cout_d  = ch_co;
          ovf_d   = ch_msb_ci ^ ch_co;
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sum       = sum_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_chunked_ripple_adder.sv
// Directed bench for chunked_ripple_adder. The main instance uses CHUNK=4;
// CHUNK=1 and CHUNK=16 instances share the stimulus and join the final sweep.
module tb_chunked_ripple_adder;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, out_ready, carry_in, sub;
  logic [W-1:0] a, b;

  logic         ir4, ov4, co4, of4;
  logic [W-1:0] s4;
  logic         ir1, ov1, co1, of1;
  logic [W-1:0] s1;
  logic         ir16, ov16, co16, of16;
  logic [W-1:0] s16;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  chunked_ripple_adder #(.WIDTH(W), .CHUNK(4)) u_c4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir4), .a(a), .b(b),
    .carry_in(carry_in), .sub(sub), .out_valid(ov4), .out_ready(out_ready),
    .sum(s4), .carry_out(co4), .overflow(of4));

  chunked_ripple_adder #(.WIDTH(W), .CHUNK(1)) u_c1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .a(a), .b(b),
    .carry_in(carry_in), .sub(sub), .out_valid(ov1), .out_ready(out_ready),
    .sum(s1), .carry_out(co1), .overflow(of1));

  chunked_ripple_adder #(.WIDTH(W), .CHUNK(16)) u_c16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir16), .a(a), .b(b),
    .carry_in(carry_in), .sub(sub), .out_valid(ov16), .out_ready(out_ready),
    .sum(s16), .carry_out(co16), .overflow(of16));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // All tasks start and end just after a falling edge.
  task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tci, input logic tsub);
    a = ta; b = tb; carry_in = tci; sub = tsub; in_valid = 1'b1;
    #1 chk("launch/in_ready", 32'(ir4), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int start);
    int lat;
    lat = start;
    while (!ov4 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "/lat"}, 32'(lat), 32'd4);
  endtask

  task automatic check_res(input string tag, input logic [W-1:0] es,
                           input logic eco, input logic eof);
    chk({tag, "/sum"}, 32'(s4), 32'(es));
    chk({tag, "/cout"}, 32'(co4), 32'(eco));
    chk({tag, "/ovf"}, 32'(of4), 32'(eof));
  endtask

  task automatic retire(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "/retire_ov"}, 32'(ov4), 32'd0);
    chk({tag, "/retire_ir"}, 32'(ir4), 32'd1);
  endtask

  task automatic op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                    input logic tci, input logic tsub,
                    input logic [W-1:0] es, input logic eco, input logic eof);
    launch(ta, tb, tci, tsub);
    wait_done(tag, 0);
    check_res(tag, es, eco, eof);
    retire(tag);
  endtask

  // Behavioural reference for all three widths of chunking.
  task automatic sweep_one(input logic [W-1:0] ta, input logic [W-1:0] tb,
                           input logic tci, input logic tsub);
    logic [W:0]   full;
    logic [W-1:0] bb;
    logic         ci, eof;
    int           l4, l1, l16;
    bb   = tsub ? ~tb : tb;
    ci   = tsub ? 1'b1 : tci;
    full = {1'b0, ta} + {1'b0, bb} + {{W{1'b0}}, ci};
    eof  = (ta[W-1] == bb[W-1]) && (full[W-1] != ta[W-1]);
    a = ta; b = tb; carry_in = tci; sub = tsub; in_valid = 1'b1;
    #1 chk("sweep/in_ready", 32'({ir1, ir4, ir16}), 32'b111);
    @(negedge clk);
    in_valid = 1'b0;
    l4 = 0; l1 = 0; l16 = 0;
    for (int t = 1; t <= 20; t++) begin
      @(negedge clk);
      if (l4 == 0 && ov4)   l4 = t;
      if (l1 == 0 && ov1)   l1 = t;
      if (l16 == 0 && ov16) l16 = t;
    end
    chk("sweep/lat_c4", 32'(l4), 32'd4);
    chk("sweep/lat_c1", 32'(l1), 32'd16);
    chk("sweep/lat_c16", 32'(l16), 32'd1);
    chk("sweep/res_c4",  32'({co4, of4, s4}),    32'({full[W], eof, full[W-1:0]}));
    chk("sweep/res_c1",  32'({co1, of1, s1}),    32'({full[W], eof, full[W-1:0]}));
    chk("sweep/res_c16", 32'({co16, of16, s16}), 32'({full[W], eof, full[W-1:0]}));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; carry_in = 1'b0; sub = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset/in_ready", 32'(ir4), 32'd1);
    chk("reset/out", 32'({ov4, co4, of4, s4}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: basic add; in-flight operands are perturbed and a stray in_valid
    // is raised while busy, neither may disturb the result.
    launch(16'h1234, 16'h0FED, 1'b0, 1'b0);
    a = 16'hAAAA; b = 16'h5555; sub = 1'b1; carry_in = 1'b1; in_valid = 1'b1;
    #1 chk("t1/busy_in_ready", 32'(ir4), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    wait_done("t1", 1);
    check_res("t1", 16'h2221, 1'b0, 1'b0);
    retire("t1");
    chk("t1/held_sum", 32'(s4), 32'h2221);

    // 2: full-length carry ripple, and carry_in into a chunk boundary
    op("t2a", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    op("t2b", 16'h000F, 16'h0000, 1'b1, 1'b0, 16'h0010, 1'b0, 1'b0);

    // 3: signed overflow; subtract with borrow and carry_in ignored
    op("t3a", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    op("t3b", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);

    // 4: backpressure, then retire and accept on the same edge
    launch(16'h1111, 16'h2222, 1'b0, 1'b0);
    wait_done("t4", 0);
    check_res("t4", 16'h3333, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4/hold", 32'({ov4, ir4, s4}), 32'({1'b1, 1'b0, 16'h3333}));
    end
    out_ready = 1'b1;
    launch(16'h0002, 16'h0003, 1'b0, 1'b0);
    out_ready = 1'b0;
    wait_done("t4n", 0);
    check_res("t4n", 16'h0005, 1'b0, 1'b0);
    retire("t4n");

    // 5: reset during the second busy cycle
    launch(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("t5/rst_out", 32'({ov4, co4, of4, s4}), 32'd0);
    chk("t5/rst_in_ready", 32'(ir4), 32'd1);
    #1 rst = 1'b0;
    @(negedge clk);
    op("t5n", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);

    // 6: sweep across all three chunkings from a clean reset
    rst = 1'b1;
    #1 rst = 1'b0;
    @(negedge clk);
    sweep_one(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    sweep_one(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    sweep_one(16'h8000, 16'h0001, 1'b0, 1'b1);
    sweep_one(16'h0005, 16'h0007, 1'b1, 1'b1);
    sweep_one(16'h1234, 16'h1234, 1'b0, 1'b1);
    sweep_one(16'h8000, 16'h8000, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++)
      sweep_one(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
